// File: rtl/hpi_arbiter_if.sv
// Request/response handshake between HPI client logic and hpi_arbiter.
// The client side uses the master modport. The arbiter side uses the slave modport.
interface hpi_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [1:0]  req_mem;
  logic [3:0]  req_reg;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_mem, req_reg, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_mem, req_reg, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/hpi_arbiter.sv
// Two-port round-robin arbiter and pin-level cycle sequencer for the CY7C67300 HPI.
// Each transaction is one direct register access, or an ADDRESS write followed by a DATA access.
module hpi_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic         clk,
  input  logic         reset,
  hpi_arbiter_if.slave bus,
  output logic [1:0]   hpi_address,
  inout  wire  [15:0]  hpi_data,
  output logic         hpi_oen,
  output logic         hpi_wen,
  output logic         hpi_csn,
  input  logic         hpi_irq,
  output logic         hpi_resetn
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state, state_n;
  logic          phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ptr;
  logic          id_q, write_q, mem_q;
  logic [1:0]    reg_q;
  logic [15:0]   addr_q, wdata_q, rd_q, dout;
  logic          data_oe;

  wire irq_unused = hpi_irq;

  assign hpi_resetn = ~reset;
  assign hpi_data   = data_oe ? dout : 16'hzzzz;

  // Arbitration: the pointer only breaks ties and flips to the other index after every grant.
  logic        gnt_id, grant, illegal;
  logic        g_write, g_mem;
  logic [1:0]  g_reg;
  logic [15:0] g_addr, g_wdata;

  assign gnt_id  = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
  assign grant   = (state == IDLE) && (bus.req_valid != 2'b00) && !reset;
  assign bus.req_ready = grant ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign g_write = bus.req_write[gnt_id];
  assign g_mem   = bus.req_mem[gnt_id];
  assign g_reg   = gnt_id ? bus.req_reg[3:2]    : bus.req_reg[1:0];
  assign g_addr  = gnt_id ? bus.req_addr[31:16] : bus.req_addr[15:0];
  assign g_wdata = gnt_id ? bus.req_wdata[31:16] : bus.req_wdata[15:0];
  assign illegal = !g_mem && ((g_write && g_reg == REG_STATUS) ||
                              (!g_write && g_reg == REG_ADDRESS));

  // Transaction fields as seen by the next state: live request on the grant cycle, latched after.
  logic        f_id, f_write, f_mem;
  logic [1:0]  f_reg;
  logic [15:0] f_addr, f_wdata;
  logic        in_idle, last_phase;

  assign in_idle    = (state == IDLE);
  assign f_id       = in_idle ? gnt_id  : id_q;
  assign f_write    = in_idle ? g_write : write_q;
  assign f_mem      = in_idle ? g_mem   : mem_q;
  assign f_reg      = in_idle ? g_reg   : reg_q;
  assign f_addr     = in_idle ? g_addr  : addr_q;
  assign f_wdata    = in_idle ? g_wdata : wdata_q;
  assign last_phase = !mem_q || phase;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    case (state)
      IDLE: if (grant) begin
        phase_n = 1'b0;
        state_n = illegal ? DONE : SETUP;
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = '0;
      end
      STROBE: if (cnt == S_LAST) state_n = HOLD;
              else               cnt_n   = cnt + 1'b1;
      HOLD: if (GAP_CYCLES == 0) begin
        state_n = last_phase ? DONE : SETUP;
        phase_n = phase | !last_phase;
      end else begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: if (cnt == G_LAST) begin
        state_n = last_phase ? DONE : SETUP;
        phase_n = phase | !last_phase;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin values for the upcoming cycle, so every HPI pin comes straight from a flop.
  logic        addr_phase, ph_write, bus_n;
  logic [1:0]  ph_reg;
  logic [15:0] ph_data;

  assign addr_phase = f_mem && !phase_n;
  assign ph_write   = addr_phase || f_write;
  assign ph_reg     = f_mem ? (phase_n ? REG_DATA : REG_ADDRESS) : f_reg;
  assign ph_data    = addr_phase ? f_addr : f_wdata;
  assign bus_n      = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= 1'b0;
      cnt           <= '0;
      ptr           <= 1'b0;
      hpi_csn       <= 1'b1;
      hpi_oen       <= 1'b1;
      hpi_wen       <= 1'b1;
      hpi_address   <= 2'd0;
      data_oe       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 16'h0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      cnt           <= cnt_n;
      if (grant) ptr <= ~gnt_id;
      hpi_csn       <= !bus_n;
      hpi_oen       <= !(state_n == STROBE && !ph_write);
      hpi_wen       <= !(state_n == STROBE && ph_write);
      data_oe       <= bus_n && ph_write;
      if (bus_n) hpi_address <= ph_reg;
      bus.rsp_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        bus.rsp_id    <= f_id;
        bus.rsp_err   <= in_idle;
        bus.rsp_rdata <= (in_idle || write_q) ? 16'h0 : rd_q;
      end
    end
  end

  // NOTE: payload registers carry no reset; they are always loaded before anything consumes them.
  always_ff @(posedge clk) begin
    if (grant) begin
      id_q    <= gnt_id;
      write_q <= g_write;
      mem_q   <= g_mem;
      reg_q   <= g_reg;
      addr_q  <= g_addr;
      wdata_q <= g_wdata;
    end
    if (bus_n) dout <= ph_data;
    // Read data is taken on the edge that ends the last STROBE cycle and raises hpi_oen.
    if (state == STROBE && state_n == HOLD) rd_q <= hpi_data;
  end
endmodule

// File: tb/tb_hpi_arbiter.sv
// Bench for hpi_arbiter: two instances (S=2,G=1 and S=1,G=0) against a per-cycle transaction model.
// Directed transactions also pin latency, read data, error and grant order to hand-computed literals.
module tb_hpi_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  bit   rst_edge = 1'b0;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hpi_arbiter_if if_a ();
  hpi_arbiter_if if_b ();

  wire  [15:0] data_a, data_b;
  logic [1:0]  addr_a, addr_b;
  logic        oen_a, wen_a, csn_a, resetn_a;
  logic        oen_b, wen_b, csn_b, resetn_b;
  logic [15:0] dev_rd [2];

  hpi_arbiter #(.STROBE_CYCLES(2), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .hpi_address(addr_a), .hpi_data(data_a),
    .hpi_oen(oen_a), .hpi_wen(wen_a), .hpi_csn(csn_a), .hpi_irq(1'b0), .hpi_resetn(resetn_a)
  );

  hpi_arbiter #(.STROBE_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .hpi_address(addr_b), .hpi_data(data_b),
    .hpi_oen(oen_b), .hpi_wen(wen_b), .hpi_csn(csn_b), .hpi_irq(1'b0), .hpi_resetn(resetn_b)
  );

  // Released bus floats high; the device drives read data while hpi_oen is low.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data_a[i]);
    pullup (data_b[i]);
  end
  assign data_a = (oen_a == 1'b0) ? dev_rd[0] : 16'hzzzz;
  assign data_b = (oen_b == 1'b0) ? dev_rd[1] : 16'hzzzz;

  logic [1:0]  v_valid [2], v_write [2], v_mem [2];
  logic [3:0]  v_reg   [2];
  logic [31:0] v_addr  [2], v_wdata [2];

  assign if_a.req_valid = v_valid[0];  assign if_b.req_valid = v_valid[1];
  assign if_a.req_write = v_write[0];  assign if_b.req_write = v_write[1];
  assign if_a.req_mem   = v_mem[0];    assign if_b.req_mem   = v_mem[1];
  assign if_a.req_reg   = v_reg[0];    assign if_b.req_reg   = v_reg[1];
  assign if_a.req_addr  = v_addr[0];   assign if_b.req_addr  = v_addr[1];
  assign if_a.req_wdata = v_wdata[0];  assign if_b.req_wdata = v_wdata[1];

  logic [1:0]  o_ready [2], o_addr [2];
  logic        o_rv [2], o_id [2], o_err [2], o_csn [2], o_oen [2], o_wen [2];
  logic [15:0] o_rdata [2], o_data [2];

  assign o_ready[0] = if_a.req_ready;  assign o_ready[1] = if_b.req_ready;
  assign o_rv[0]    = if_a.rsp_valid;  assign o_rv[1]    = if_b.rsp_valid;
  assign o_id[0]    = if_a.rsp_id;     assign o_id[1]    = if_b.rsp_id;
  assign o_err[0]   = if_a.rsp_err;    assign o_err[1]   = if_b.rsp_err;
  assign o_rdata[0] = if_a.rsp_rdata;  assign o_rdata[1] = if_b.rsp_rdata;
  assign o_csn[0]   = csn_a;           assign o_csn[1]   = csn_b;
  assign o_oen[0]   = oen_a;           assign o_oen[1]   = oen_b;
  assign o_wen[0]   = wen_a;           assign o_wen[1]   = wen_b;
  assign o_addr[0]  = addr_a;          assign o_addr[1]  = addr_b;
  assign o_data[0]  = data_a;          assign o_data[1]  = data_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding transaction per unit, described by its grant cycle.
  int S_OF [2] = '{2, 1};
  int G_OF [2] = '{1, 0};
  bit          m_busy [2], m_ptr [2], m_id [2], m_write [2], m_mem [2], m_err [2];
  int          m_t0 [2], m_len [2];
  logic [1:0]  m_reg [2];
  logic [15:0] m_addr [2], m_wdata [2], m_rd [2], m_last [2];

  task automatic model_step(input int u);
    int p, nph, k, ph, off, gi;
    bit gid, in_bus, stb, ph_wr, exp_rv;
    logic [1:0]  exp_rdy, exp_adr;
    logic [15:0] exp_dat;
    string t;
    t = $sformatf("u%0d cyc%0d", u, cyc);
    p = 2 + S_OF[u] + G_OF[u];
    if (rst_edge) begin
      m_busy[u] = 1'b0;
      m_ptr[u]  = 1'b0;
      m_last[u] = 16'h0;
    end
    if (m_busy[u] && cyc > m_t0[u] + m_len[u]) m_busy[u] = 1'b0;
    exp_rdy = 2'b00;
    if (!m_busy[u] && !reset && v_valid[u] != 2'b00) begin
      gid = (v_valid[u] == 2'b11) ? m_ptr[u] : v_valid[u][1];
      gi  = int'(gid);
      exp_rdy[gi] = 1'b1;
      m_ptr[u]   = !gid;
      m_id[u]    = gid;
      m_busy[u]  = 1'b1;
      m_t0[u]    = cyc;
      m_write[u] = v_write[u][gi];
      m_mem[u]   = v_mem[u][gi];
      m_reg[u]   = v_reg[u][2*gi +: 2];
      m_addr[u]  = v_addr[u][16*gi +: 16];
      m_wdata[u] = v_wdata[u][16*gi +: 16];
      m_rd[u]    = dev_rd[u];
      m_err[u]   = !m_mem[u] && ((m_write[u] && m_reg[u] == 2'd3) ||
                                 (!m_write[u] && m_reg[u] == 2'd2));
      m_len[u]   = m_err[u] ? 1 : (m_mem[u] ? 2 : 1) * p + 1;
    end
    in_bus = 1'b0; stb = 1'b0; ph_wr = 1'b0; exp_rv = 1'b0;
    exp_adr = 2'd0; exp_dat = 16'h0;
    if (m_busy[u]) begin
      k   = cyc - m_t0[u];
      nph = m_mem[u] ? 2 : 1;
      if (!m_err[u] && k >= 1 && k <= nph * p) begin
        ph      = (k - 1) / p;
        off     = (k - 1) % p;
        in_bus  = (off <= S_OF[u] + 1);
        stb     = (off >= 1) && (off <= S_OF[u]);
        ph_wr   = (m_mem[u] && ph == 0) || m_write[u];
        exp_adr = !m_mem[u] ? m_reg[u] : ((ph == 0) ? 2'd2 : 2'd0);
        exp_dat = (m_mem[u] && ph == 0) ? m_addr[u] : m_wdata[u];
      end
      if (k == m_len[u]) begin
        exp_rv    = 1'b1;
        m_last[u] = (m_err[u] || m_write[u]) ? 16'h0 : m_rd[u];
      end
    end
    check({"req_ready ", t}, 32'(o_ready[u]), 32'(exp_rdy));
    check({"hpi_csn ", t}, 32'(o_csn[u]), 32'(!in_bus));
    check({"hpi_oen ", t}, 32'(o_oen[u]), 32'(!(stb && !ph_wr)));
    check({"hpi_wen ", t}, 32'(o_wen[u]), 32'(!(stb && ph_wr)));
    check({"rsp_valid ", t}, 32'(o_rv[u]), 32'(exp_rv));
    check({"rsp_rdata ", t}, 32'(o_rdata[u]), 32'(m_last[u]));
    if (exp_rv) begin
      check({"rsp_id ", t}, 32'(o_id[u]), 32'(m_id[u]));
      check({"rsp_err ", t}, 32'(o_err[u]), 32'(m_err[u]));
    end
    if (in_bus) check({"hpi_address ", t}, 32'(o_addr[u]), 32'(exp_adr));
    if (in_bus && ph_wr)    check({"hpi_data ", t}, 32'(o_data[u]), 32'(exp_dat));
    else if (!stb || ph_wr) check({"hpi_data released ", t}, 32'(o_data[u]), 32'hFFFF);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
    if (reset) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic run_txn(input int u, input int id, input bit wr, input bit mem,
                         input logic [1:0] rg, input logic [15:0] ad, input logic [15:0] wd,
                         input logic [15:0] dev, input int exp_lat, input logic [15:0] exp_rd,
                         input bit exp_err, input string nm);
    int g, lat;
    bit got;
    g = 0; lat = 0;
    @(posedge clk); #1;
    dev_rd[u]               = dev;
    v_write[u][id]          = wr;
    v_mem[u][id]            = mem;
    v_reg[u][2*id +: 2]     = rg;
    v_addr[u][16*id +: 16]  = ad;
    v_wdata[u][16*id +: 16] = wd;
    v_valid[u][id]          = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (o_ready[u][id]) begin got = 1'b1; g = cyc; end
    end
    check({nm, " granted"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    v_valid[u][id] = 1'b0;
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        if (o_rv[u]) begin got = 1'b1; lat = cyc - g; end
      end
      check({nm, " response seen"}, 32'(got), 32'd1);
      if (got) begin
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " rdata"}, 32'(o_rdata[u]), 32'(exp_rd));
        check({nm, " err"}, 32'(o_err[u]), 32'(exp_err));
        check({nm, " id"}, 32'(o_id[u]), 32'(id));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq [4];
    int ng, g, nrsp;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      v_valid[u] = '0; v_write[u] = '0; v_mem[u] = '0;
      v_reg[u] = '0; v_addr[u] = '0; v_wdata[u] = '0; dev_rd[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hpi_resetn in reset", 32'(resetn_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset hpi_csn", 32'(csn_a), 32'd1);
    check("reset hpi_oen", 32'(oen_a), 32'd1);
    check("reset hpi_wen", 32'(wen_a), 32'd1);
    check("reset hpi_address", 32'(addr_a), 32'd0);
    check("reset hpi_data", 32'(data_a), 32'hFFFF);
    check("reset rsp_valid", 32'(if_a.rsp_valid), 32'd0);
    check("reset rsp_rdata", 32'(if_a.rsp_rdata), 32'd0);
    check("reset rsp_id", 32'(if_a.rsp_id), 32'd0);
    check("hpi_resetn out of reset", 32'(resetn_a), 32'd1);

    run_txn(0, 0, 1'b0, 1'b0, 2'd1, 16'h0, 16'h0, 16'h1234, 6, 16'h1234, 1'b0, "mbx_rd");
    run_txn(0, 1, 1'b1, 1'b1, 2'd0, 16'h1324, 16'hCAFE, 16'h0, 11, 16'h0, 1'b0, "mem_wr");

    // Both requesters held valid: grants must alternate starting at requester 0.
    @(posedge clk); #1;
    v_write[0] = 2'b11; v_mem[0] = 2'b00; v_reg[0] = 4'b0101;
    v_wdata[0] = 32'h2222_1111;
    v_valid[0] = 2'b11;
    ng = 0;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      @(negedge clk);
      if (o_ready[0] == 2'b01) begin gseq[ng] = 0; ng++; end
      else if (o_ready[0] == 2'b10) begin gseq[ng] = 1; ng++; end
    end
    @(posedge clk); #1;
    v_valid[0] = 2'b00;
    check("rr grant count", 32'(ng), 32'd4);
    check("rr grant 0", 32'(gseq[0]), 32'd0);
    check("rr grant 1", 32'(gseq[1]), 32'd1);
    check("rr grant 2", 32'(gseq[2]), 32'd0);
    check("rr grant 3", 32'(gseq[3]), 32'd1);
    repeat (12) @(posedge clk);

    run_txn(0, 0, 1'b1, 1'b0, 2'd3, 16'h0, 16'h5555, 16'h0, 1, 16'h0, 1'b1, "status_wr");
    run_txn(0, 1, 1'b0, 1'b0, 2'd2, 16'h0, 16'h0, 16'h7777, 1, 16'h0, 1'b1, "address_rd");

    // Reset during cycle 3 of a direct read: no response, then normal service resumes.
    @(posedge clk); #1;
    dev_rd[0] = 16'h4321;
    v_write[0] = 2'b00; v_mem[0] = 2'b00; v_reg[0] = 4'b0000;
    v_valid[0] = 2'b01;
    g = -1;
    for (int i = 0; i < 60 && g < 0; i++) begin
      @(negedge clk);
      if (o_ready[0][0]) g = cyc;
    end
    check("reset test granted", 32'(g >= 0), 32'd1);
    @(posedge clk); #1;
    v_valid[0] = 2'b00;
    for (int i = 0; i < 10 && cyc < g + 3; i++) @(negedge clk);
    reset = 1'b1;
    nrsp = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("strobes high after abort", 32'({csn_a, oen_a, wen_a}), 32'b111);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (o_rv[0]) nrsp++;
    end
    check("no response after abort", 32'(nrsp), 32'd0);
    run_txn(0, 0, 1'b0, 1'b1, 2'd0, 16'h0100, 16'h0, 16'hBEEF, 11, 16'hBEEF, 1'b0, "mem_rd_after_rst");

    run_txn(1, 0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0F0F, 4, 16'h0F0F, 1'b0, "fast_dir_rd");
    run_txn(1, 1, 1'b1, 1'b1, 2'd0, 16'h2000, 16'h00AA, 16'h0, 7, 16'h0, 1'b0, "fast_mem_wr");

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
